acumulador_suma: RTL and testbench

- Sequential accumulator stage placed directly downstream of the N-bit ripple adder `suma`. It instantiates `suma #(N)` and feeds its sum and carry back into a registered accumulator.
- It accepts a burst of operands over a valid/ready handshake and adds or subtracts each one into the running total.
- At the end of the burst it presents the result with flags until the consumer accepts it.

---
 rtl/acumulador_suma.sv | 202 ++++++++++++++++++++
 tb/tb_acumulador_suma.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_suma.sv
// acumulador_suma: burst accumulator built around the ripple adder `suma`.
// Accepts a burst of len operands over in_valid/in_ready, adds or subtracts
// each into a registered accumulator, and holds the result with sticky flags
// on out_valid until out_ready.
// Optional build macro: ACUMULADOR_SATURATE_EN (saturate acc on unsigned overflow).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, len, clear     burst start / length (0 means 1) / synchronous abort
//   in_valid/in_ready     operand handshake; in_data operand, in_op 0=add 1=sub
//   out_valid/out_ready   result handshake
//   acc, carry, ovf       accumulator, sticky unsigned / signed overflow
//   zero, neg, count      acc==0 (combinational), acc MSB, beats accepted

// N-bit ripple-carry adder: s = a + b + cin, cout is the carry out.
module suma #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic w_c;

   // Full-adder chain, LSB first.
   always_comb begin
      s   = '0;
      w_c = cin;
      for (int i = 0; i < int'(N); i++) begin
         s[i] = a[i] ^ b[i] ^ w_c;
         w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
      end
      cout = w_c;
   end

endmodule

module acumulador_suma #(
   parameter int unsigned N = 8,
   parameter int unsigned C = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [C-1:0] len,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] acc,
   output logic         carry,
   output logic         ovf,
   output logic         zero,
   output logic         neg,
   output logic [C-1:0] count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACUM = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [N-1:0] r_acc;
   logic         r_carry;
   logic         r_ovf;
   logic [C-1:0] r_count;
   logic [C-1:0] r_len;
   logic         r_in_ready;
   logic         r_out_valid;

   logic [N-1:0] w_b;
   logic [N-1:0] w_s;
   logic         w_cout;
   logic         w_uevt;
   logic         w_sevt;
   logic [N-1:0] w_acc_nxt;
   logic         w_start;
   logic         w_beat;
   logic         w_last;

   // Subtraction is a + ~b + 1, so in_op doubles as the carry-in.
   assign w_b = in_op ? ~in_data : in_data;

   suma #(.N(N)) u_suma (
      .a    (r_acc),
      .b    (w_b),
      .cin  (in_op),
      .s    (w_s),
      .cout (w_cout)
   );

   // A missing carry-out on subtract is a borrow.
   assign w_uevt = in_op ? ~w_cout : w_cout;
   assign w_sevt = (r_acc[N-1] == w_b[N-1]) && (w_s[N-1] != r_acc[N-1]);

`ifdef ACUMULADOR_SATURATE_EN
   // Clamp to the rail crossed; ovf still comes from the raw sum.
   assign w_acc_nxt = w_uevt ? (in_op ? {N{1'b0}} : {N{1'b1}}) : w_s;
`else
   assign w_acc_nxt = w_s;
`endif

   assign w_last = (r_count == (r_len - C'(1)));

   // Next-state and transfer qualifiers; clear overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_beat      = 1'b0;
      if (clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_start     = 1'b1;
                  w_state_nxt = S_ACUM;
               end
            end
            S_ACUM: begin
               if (in_valid && r_in_ready) begin
                  w_beat = 1'b1;
                  if (w_last) begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == S_ACUM);
         r_out_valid <= (w_state_nxt == S_DONE);
      end
   end

   // Accumulator datapath and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= '0;
         r_len   <= C'(1);
      end else if (clear) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= '0;
      end else if (w_start) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_count <= '0;
         r_len   <= (len == '0) ? C'(1) : len;
      end else if (w_beat) begin
         r_acc   <= w_acc_nxt;
         r_carry <= r_carry | w_uevt;
         r_ovf   <= r_ovf | w_sevt;
         r_count <= r_count + C'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign acc       = r_acc;
   assign carry     = r_carry;
   assign ovf       = r_ovf;
   assign count     = r_count;
   assign zero      = (r_acc == '0);
   assign neg       = r_acc[N-1];

endmodule

// File: tb/tb_acumulador_suma.sv
// Self-checking bench for acumulador_suma: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// an arithmetic model of the accumulator.
module tb_acumulador_suma;

   localparam int unsigned N = 8;
   localparam int unsigned C = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [C-1:0] len;
   logic         clear;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] acc;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic         neg;
   logic [C-1:0] count;

   acumulador_suma #(.N(N), .C(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg),
      .count     (count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 accumulating, 2 result held.
   int m_phase = 0;
   int m_acc   = 0;
   int m_cnt   = 0;
   int m_len   = 1;
   bit m_carry = 1'b0;
   bit m_ovf   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0;
      end else if (clear) begin
         m_phase = 0; m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_len = (len == 0) ? 1 : int'(len);
               m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0;
               m_phase = 1;
            end
            1: if (in_valid) begin
               int d, r, sa, sd, sr;
               bit uev;
               d  = int'(in_data);
               sa = (m_acc >= 128) ? m_acc - 256 : m_acc;
               sd = (d >= 128) ? d - 256 : d;
               if (!in_op) begin
                  r = m_acc + d; uev = (r > 255); sr = sa + sd;
               end else begin
                  r = m_acc - d; uev = (r < 0);   sr = sa - sd;
               end
               r = r & 255;
`ifdef ACUMULADOR_SATURATE_EN
               if (uev) r = in_op ? 0 : 255;
`endif
               m_acc   = r;
               m_carry = m_carry | uev;
               m_ovf   = m_ovf | (sr > 127 || sr < -128);
               m_cnt   = m_cnt + 1;
               if (m_cnt == m_len) m_phase = 2;
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("acc",       32'(acc),       32'(m_acc));
         chk("carry",     32'(carry),     32'(m_carry));
         chk("ovf",       32'(ovf),       32'(m_ovf));
         chk("zero",      32'(zero),      32'(m_acc == 0));
         chk("neg",       32'(neg),       32'(m_acc >= 128));
         chk("count",     32'(count),     32'(m_cnt));
         chk("in_ready",  32'(in_ready),  32'(m_phase == 1));
         chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(input int l);
      start = 1'b1; len = C'(l);
      step();
      start = 1'b0;
   endtask

   task automatic do_beat(input int d, input bit op);
      in_valid = 1'b1; in_data = N'(d); in_op = op;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; clear = 1'b0;
      in_valid = 1'b0; in_data = '0; in_op = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_acc", 32'(acc), 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("idle_in_ready", 32'(in_ready), 0);

      // 10 + 20 + 30
      do_start(3);
      do_beat(10, 0); do_beat(20, 0); do_beat(30, 0);
      chk("t1_acc", 32'(acc), 60);
      chk("t1_out_valid", 32'(out_valid), 1);
      chk("t1_carry", 32'(carry), 0);
      chk("t1_ovf", 32'(ovf), 0);
      chk("t1_count", 32'(count), 3);

      // Hold in DONE with start asserted: nothing moves.
      start = 1'b1; len = C'(2);
      repeat (5) begin
         step();
         chk("hold_acc", 32'(acc), 60);
         chk("hold_out_valid", 32'(out_valid), 1);
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b0;
      chk("accept_out_valid", 32'(out_valid), 0);
      chk("accept_acc_kept", 32'(acc), 60);
      step();
      chk("start_ignored_in_ready", 32'(in_ready), 0);

      // 200 + 100 wraps (or saturates)
      do_start(2);
      do_beat(200, 0); do_beat(100, 0);
`ifdef ACUMULADOR_SATURATE_EN
      chk("t2_acc", 32'(acc), 255);
`else
      chk("t2_acc", 32'(acc), 44);
`endif
      chk("t2_carry", 32'(carry), 1);
      chk("t2_ovf", 32'(ovf), 0);
      do_accept();

      // 100 + 100 signed overflow
      do_start(2);
      do_beat(100, 0); do_beat(100, 0);
      chk("t3_acc", 32'(acc), 200);
      chk("t3_carry", 32'(carry), 0);
      chk("t3_ovf", 32'(ovf), 1);
      chk("t3_neg", 32'(neg), 1);
      do_accept();

      // 5 - 7 borrow
      do_start(2);
      do_beat(5, 0); do_beat(7, 1);
`ifdef ACUMULADOR_SATURATE_EN
      chk("t4_acc", 32'(acc), 0);
      chk("t4_zero", 32'(zero), 1);
`else
      chk("t4_acc", 32'(acc), 254);
      chk("t4_neg", 32'(neg), 1);
`endif
      chk("t4_carry", 32'(carry), 1);
      do_accept();

      // Gaps in in_valid
      do_start(3);
      do_beat(1, 0);
      step(); step();
      chk("gap_acc", 32'(acc), 1);
      chk("gap_count", 32'(count), 1);
      do_beat(2, 0); step(); do_beat(3, 0);
      chk("gap_final_acc", 32'(acc), 6);
      do_accept();

      // Abort after one beat of four
      do_start(4);
      do_beat(7, 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_acc", 32'(acc), 0);
      chk("clr_count", 32'(count), 0);
      chk("clr_in_ready", 32'(in_ready), 0);
      repeat (4) begin
         step();
         chk("clr_no_out_valid", 32'(out_valid), 0);
      end

      // len = 0 behaves as 1
      do_start(0);
      do_beat(9, 0);
      chk("len0_out_valid", 32'(out_valid), 1);
      chk("len0_count", 32'(count), 1);
      do_accept();

      // Maximum burst
      do_start(15);
      for (int i = 0; i < 15; i++) do_beat(1, 0);
      chk("max_count", 32'(count), 15);
      chk("max_acc", 32'(acc), 15);
      chk("max_out_valid", 32'(out_valid), 1);
      do_accept();

      // Reset mid-burst
      do_start(3);
      do_beat(50, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_acc", 32'(acc), 0);
      chk("mrst_zero", 32'(zero), 1);
      chk("mrst_in_ready", 32'(in_ready), 0);
      chk("mrst_count", 32'(count), 0);
      #2 rst_n = 1'b1;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 9) == 0);
         len       = C'($urandom_range(0, 15));
         clear     = ($urandom_range(0, 63) == 0);
         in_valid  = ($urandom_range(0, 9) < 6);
         in_data   = N'($urandom);
         in_op     = 1'($urandom);
         out_ready = ($urandom_range(0, 9) < 3);
         step();
      end
      start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
